// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
//   uart_tx_state_t : serialiser FSM states
//   UART_LINE_IDLE  : level of the idle / stop-bit line
//   UART_DATA_BITS  : payload bits per frame (8N1)
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam logic UART_LINE_IDLE = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: CPU-side write port and status/serial outputs of the
// buffered UART transmitter.
//   wr_en/wr_data          : byte push strobe and data (master -> slave)
//   full/level/busy        : FIFO and serialiser status (slave -> master)
//   overflow               : sticky dropped-write flag (slave -> master)
//   tx                     : serial line, idle high (slave -> master)
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [LW-1:0] level;
  logic          busy;
  logic          overflow;
  logic          tx;

  modport master (output wr_en, wr_data,
                  input  full, level, busy, overflow, tx);
  modport slave  (input  wr_en, wr_data,
                  output full, level, busy, overflow, tx);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, btnc        : clock, async active-high reset
//   wr_en, wr_data   : push (ignored while full)
//   rd_en, rd_data   : pop (ignored while empty); rd_data always shows the head
//   full, empty      : decoded from the registered entry count
//   level            : entries currently stored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   btnc,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  // full comes from the registered count, so a pop in the same cycle does
  // not let a write through
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge btnc) begin
    if (btnc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter.
//   clk, btnc : clock, async active-high reset (aborts any frame in flight)
//   bus       : slave side of uart_tx_buffered_if (write port, status, tx)
// Bytes are queued in sync_fifo and shifted out LSB-first, CLKS_PER_BIT
// cycles per bit. Frames queued back-to-back leave no idle gap on the line.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                btnc,
  uart_tx_buffered_if.slave   bus
);
  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt, cnt_inc;
  logic [BW-1:0]             bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] shift, shift_nxt, head;
  logic [LW-1:0]             level;
  logic                      pop, fifo_full, fifo_empty;
  logic                      tx_q, tx_nxt, overflow, bit_end;

  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .btnc    (btnc),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign bit_end = (cnt == CNT_LAST);
  assign cnt_inc = bit_end ? '0 : cnt + 1'b1;

  // tx_nxt is decoded from the current state and registered, so the line
  // trails the FSM by one cycle uniformly (no glitches on the pin)
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    tx_nxt      = UART_LINE_IDLE;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_nxt   = head;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        tx_nxt  = 1'b0;
        cnt_nxt = cnt_inc;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt  = shift[0];
        cnt_nxt = cnt_inc;
        if (bit_end) begin
          shift_nxt   = shift >> 1;
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        cnt_nxt = cnt_inc;
        if (bit_end) begin
          // chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            pop         = 1'b1;
            shift_nxt   = head;
            bit_idx_nxt = '0;
            state_nxt   = START;
          end else begin
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge btnc) begin
    if (btnc) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= UART_LINE_IDLE;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx_q    <= tx_nxt;
    end
  end

  always_ff @(posedge clk or posedge btnc) begin
    if (btnc)                         overflow <= 1'b0;
    else if (bus.wr_en && fifo_full)  overflow <= 1'b1;
  end

  assign bus.full     = fifo_full;
  assign bus.level    = level;
  assign bus.busy     = (state != IDLE) || !fifo_empty;
  assign bus.overflow = overflow;
  assign bus.tx       = tx_q;
endmodule
